// File: rtl/riscv_pkg.sv
// Shared types and constants for the multicycle RV32I control path.
package riscv_pkg;

    localparam int unsigned STATE_W = 4;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } mc_state_e;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I      = 2'b00;
    localparam logic [1:0] IMM_S      = 2'b01;
    localparam logic [1:0] IMM_B      = 2'b10;
    localparam logic [1:0] IMM_J      = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR fields and status in, mux selects and enables out.
interface multicycle_controller_if;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero_flg;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       instr_retired;
    logic       illegal;
    logic [riscv_pkg::STATE_W-1:0] state_o;

    modport master (
        input  opcode, funct3, funct7b5, zero_flg, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, instr_retired, illegal, state_o
    );

    modport slave (
        output opcode, funct3, funct7b5, zero_flg, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, instr_retired, illegal, state_o
    );

endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU request and the instruction's funct fields onto an ALU operation.
module alu_decoder
    import riscv_pkg::*;
(
    input  alu_op_e    alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output alu_ctrl_e  alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB: alu_ctrl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // only R-type distinguishes sub; addi has no funct7
                    3'b000:  alu_ctrl_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl_o = ALU_SLT;
                    3'b110:  alu_ctrl_o = ALU_OR;
                    3'b111:  alu_ctrl_o = ALU_AND;
                    default: alu_ctrl_o = ALU_ADD;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: fetch, decode, execute, memory, writeback.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);

    mc_state_e state_q, state_d;
    logic      illegal_q;
    alu_op_e   alu_op;
    alu_ctrl_e alu_ctrl;
    logic      pc_write, ir_write, mem_write, reg_write;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
                    OPC_RTYPE:           state_d = S_EXECUTER;
                    OPC_ITYPE:           state_d = S_EXECUTEI;
                    OPC_BRANCH:          state_d = S_BEQ;
                    OPC_JAL:             state_d = S_JAL;
                    default:             state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore decode; mem_ready and zero_flg are the only input-dependent terms
    always_comb begin
        pc_write          = 1'b0;
        ir_write          = 1'b0;
        mem_write         = 1'b0;
        reg_write         = 1'b0;
        bus.instr_retired = 1'b0;
        bus.AdrSrc        = ADR_PC;
        bus.ResultSrc     = RES_ALUOUT;
        bus.ALUSrcA       = SRCA_PC;
        bus.ALUSrcB       = SRCB_RS2;
        alu_op            = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALU;
                ir_write      = bus.mem_ready;
                pc_write      = bus.mem_ready;
            end
            S_DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  bus.AdrSrc = ADR_ALUOUT;
            S_MEMWB: begin
                bus.ResultSrc     = RES_DATA;
                reg_write         = 1'b1;
                bus.instr_retired = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc        = ADR_ALUOUT;
                mem_write         = 1'b1;
                bus.instr_retired = bus.mem_ready;
            end
            S_EXECUTER: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_RS2;
                alu_op      = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
                alu_op      = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write         = 1'b1;
                bus.instr_retired = 1'b1;
            end
            S_BEQ: begin
                bus.ALUSrcA       = SRCA_RS1;
                bus.ALUSrcB       = SRCB_RS2;
                alu_op            = ALUOP_SUB;
                pc_write          = bus.zero_flg;
                bus.instr_retired = 1'b1;
            end
            S_JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                pc_write    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (bus.opcode)
            OPC_STORE:  bus.ImmSrc = IMM_S;
            OPC_BRANCH: bus.ImmSrc = IMM_B;
            OPC_JAL:    bus.ImmSrc = IMM_J;
            default:    bus.ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i   (alu_op),
        .funct3_i   (bus.funct3),
        .op5_i      (bus.opcode[5]),
        .funct7b5_i (bus.funct7b5),
        .alu_ctrl_o (alu_ctrl)
    );

    // architectural-state enables are held off while reset is asserted
    assign bus.PCWrite    = pc_write  & rst_n;
    assign bus.IRWrite    = ir_write  & rst_n;
    assign bus.MemWrite   = mem_write & rst_n;
    assign bus.RegWrite   = reg_write & rst_n;
    assign bus.ALUControl = alu_ctrl;
    assign bus.illegal    = illegal_q;
    assign bus.state_o    = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP) illegal_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-stream bench for multicycle_controller against a per-instruction phase model.
module tb_multicycle_controller;
    import riscv_pkg::*;

    localparam int K_R   = 0;
    localparam int K_I   = 1;
    localparam int K_LW  = 2;
    localparam int K_SW  = 3;
    localparam int K_BEQ = 4;
    localparam int K_JAL = 5;
    localparam int K_ILL = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [1:0] exp_imm;
    logic       exp_ill;

    always #5 clk = ~clk;

    multicycle_controller_if bus ();
    multicycle_controller_if bus_nop ();

    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nop)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] sel(input logic adr, input logic [1:0] res,
                                       input logic [1:0] a, input logic [1:0] b);
        return {adr, res, a, b};
    endfunction

    // Operation an R/I arithmetic instruction performs.
    function automatic alu_ctrl_e arith_op(input logic is_r, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'd2:    return ALU_SLT;
            3'd6:    return ALU_OR;
            3'd7:    return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    // One clock: drive inputs, sample at the falling edge, then advance past the rising edge.
    task automatic step(input mc_state_e st, input logic rdy, input logic zf,
                        input logic [4:0] en, input logic [6:0] sl, input alu_ctrl_e aluc);
        bus.mem_ready = rdy;
        bus.zero_flg  = zf;
        #4;
        check_eq("state", 32'(bus.state_o), 32'(st));
        check_eq("enables", 32'({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite,
                                 bus.instr_retired}), 32'(en));
        check_eq("selects", 32'({bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB}), 32'(sl));
        check_eq("alu_ctrl", 32'(bus.ALUControl), 32'(aluc));
        check_eq("imm_src", 32'(bus.ImmSrc), 32'(exp_imm));
        check_eq("illegal", 32'(bus.illegal), 32'(exp_ill));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic alu_wb();
        step(S_ALUWB, rnd(), rnd(), 5'b00011, 7'b0, ALU_ADD);
    endtask

    task automatic mem_adr();
        step(S_MEMADR, rnd(), rnd(), 5'b0, sel(1'b0, 2'b00, 2'b10, 2'b01), ALU_ADD);
    endtask

    task automatic run_instr(input int kind, input logic [2:0] f3, input logic f7,
                             input int fstall, input int mstall, input logic zf);
        logic [6:0] opc;
        logic       r;
        alu_ctrl_e  op;
        case (kind)
            K_R:     opc = 7'b0110011;
            K_I:     opc = 7'b0010011;
            K_LW:    opc = 7'b0000011;
            K_SW:    opc = 7'b0100011;
            K_BEQ:   opc = 7'b1100011;
            K_JAL:   opc = 7'b1101111;
            default: opc = 7'b1111111;
        endcase
        exp_imm = (kind == K_SW) ? 2'b01 : (kind == K_BEQ) ? 2'b10 : (kind == K_JAL) ? 2'b11 : 2'b00;
        op = arith_op(kind == K_R, f3, f7);
        bus.opcode   = opc;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        for (int i = 0; i <= fstall; i++) begin
            r = (i == fstall);
            step(S_FETCH, r, rnd(), {r, r, 3'b000}, sel(1'b0, 2'b10, 2'b00, 2'b10), ALU_ADD);
        end
        step(S_DECODE, rnd(), rnd(), 5'b0, sel(1'b0, 2'b00, 2'b01, 2'b01), ALU_ADD);
        case (kind)
            K_R: begin
                step(S_EXECUTER, rnd(), rnd(), 5'b0, sel(1'b0, 2'b00, 2'b10, 2'b00), op);
                alu_wb();
            end
            K_I: begin
                step(S_EXECUTEI, rnd(), rnd(), 5'b0, sel(1'b0, 2'b00, 2'b10, 2'b01), op);
                alu_wb();
            end
            K_LW: begin
                mem_adr();
                for (int i = 0; i <= mstall; i++)
                    step(S_MEMREAD, i == mstall, rnd(), 5'b0, sel(1'b1, 2'b00, 2'b00, 2'b00), ALU_ADD);
                step(S_MEMWB, rnd(), rnd(), 5'b00011, sel(1'b0, 2'b01, 2'b00, 2'b00), ALU_ADD);
            end
            K_SW: begin
                mem_adr();
                for (int i = 0; i <= mstall; i++) begin
                    r = (i == mstall);
                    step(S_MEMWRITE, r, rnd(), {3'b001, 1'b0, r}, sel(1'b1, 2'b00, 2'b00, 2'b00), ALU_ADD);
                end
            end
            K_BEQ: step(S_BEQ, rnd(), zf, {zf, 4'b0001}, sel(1'b0, 2'b00, 2'b10, 2'b00), ALU_SUB);
            K_JAL: begin
                step(S_JAL, rnd(), rnd(), 5'b10000, sel(1'b0, 2'b00, 2'b01, 2'b10), ALU_ADD);
                alu_wb();
            end
            default: begin
                exp_ill = 1'b1;
                for (int i = 0; i < 10; i++) step(S_TRAP, rnd(), rnd(), 5'b0, 7'b0, ALU_ADD);
            end
        endcase
    endtask

    initial begin
        rst_n            = 1'b0;
        exp_ill          = 1'b0;
        exp_imm          = 2'b00;
        bus.opcode       = 7'b0;
        bus.funct3       = 3'b0;
        bus.funct7b5     = 1'b0;
        bus.zero_flg     = 1'b0;
        bus.mem_ready    = 1'b1;
        bus_nop.opcode   = 7'h7F;
        bus_nop.funct3   = 3'b0;
        bus_nop.funct7b5 = 1'b0;
        bus_nop.zero_flg = 1'b0;
        bus_nop.mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // reset held for two cycles with mem_ready high
        for (int i = 0; i < 2; i++) begin
            #4;
            check_eq("rst_state", 32'(bus.state_o), 32'(S_FETCH));
            check_eq("rst_enables", 32'({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite,
                                         bus.instr_retired}), 32'd0);
            check_eq("rst_illegal", 32'(bus.illegal), 32'd0);
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b1;

        run_instr(K_R,   3'b000, 1'b0, 0, 0, 1'b0);  // add
        run_instr(K_R,   3'b000, 1'b1, 0, 0, 1'b0);  // sub
        run_instr(K_LW,  3'b010, 1'b0, 2, 2, 1'b0);
        run_instr(K_BEQ, 3'b000, 1'b0, 0, 0, 1'b1);
        run_instr(K_BEQ, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(K_JAL, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(K_SW,  3'b010, 1'b0, 1, 3, 1'b0);
        run_instr(K_I,   3'b000, 1'b1, 0, 0, 1'b0);  // addi with IR[30] set is still an add

        for (int n = 0; n < 60; n++)
            run_instr($urandom_range(0, 5), 3'($urandom), rnd(), $urandom_range(0, 3),
                      $urandom_range(0, 3), rnd());

        // reset lands while a store is waiting in MEMWRITE
        exp_imm      = 2'b01;
        bus.opcode   = OPC_STORE;
        bus.funct3   = 3'b010;
        bus.funct7b5 = 1'b0;
        step(S_FETCH, 1'b1, 1'b0, 5'b11000, sel(1'b0, 2'b10, 2'b00, 2'b10), ALU_ADD);
        step(S_DECODE, 1'b0, 1'b0, 5'b0, sel(1'b0, 2'b00, 2'b01, 2'b01), ALU_ADD);
        mem_adr();
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        #4;
        check_eq("abort_memwrite", 32'(bus.MemWrite), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        #4;
        check_eq("abort_state", 32'(bus.state_o), 32'(S_FETCH));
        check_eq("abort_enables", 32'({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;

        run_instr(K_R, 3'b111, 1'b0, 1, 0, 1'b0);
        run_instr(K_ILL, 3'b000, 1'b0, 0, 0, 1'b0);

        // reset clears the sticky illegal flag
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        #4;
        check_eq("trap_rst_illegal", 32'(bus.illegal), 32'd0);
        check_eq("trap_rst_state", 32'(bus.state_o), 32'(S_FETCH));
        exp_ill = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;

        // with trapping disabled, an unsupported opcode behaves as a NOP
        for (int i = 0; i < 4; i++) begin
            #4;
            check_eq("nop_state", 32'(bus_nop.state_o), (i % 2 == 0) ? 32'(S_FETCH) : 32'(S_DECODE));
            check_eq("nop_illegal", 32'(bus_nop.illegal), 32'd0);
            @(posedge clk);
            #1;
            cyc++;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
